dmem_responder: RTL and testbench

// Data-memory responder on the far side of the core's dmem_* load/store port.
// - Owns the data storage. Commits stores and returns load data after a fixed, pipelined read latency.
// - After every reset it runs a zero-fill sweep, so loads never return X.
// - Flags out-of-range addresses.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word storage behind the core's dmem load/store port, with a
// pipelined fixed-latency read path, post-reset zero-fill, access counters and OOB flag.
module dmem_responder #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_ren,
  input  logic [ADDR_W-1:0] dmem_raddr,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_waddr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_rvalid,
  output logic              busy,
  output logic              err_oob,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {StInit, StRun} state_e;
  localparam state_e StReset = CLEAR_ON_RESET ? StInit : StRun;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  // Read pipeline: stage 0 is loaded on the capture edge, the last stage drives the outputs.
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [DATA_W-1:0] pd_q [RD_LAT];
  logic [DATA_W-1:0] pd_d [RD_LAT];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              raddr_ok, waddr_ok, ld_acc;
  logic [DATA_W-1:0] ld_data;

  assign raddr_ok = {1'b0, dmem_raddr} < DEPTH_V;
  assign waddr_ok = {1'b0, dmem_waddr} < DEPTH_V;
  assign ld_acc   = (state_q == StRun) && dmem_ren;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    mem_we   = 1'b0;
    mem_wa   = dmem_waddr[IDX_W-1:0];
    mem_wd   = dmem_wdata;
    unique case (state_q)
      StInit: begin
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = '0;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we = dmem_wen && waddr_ok;
        if (dmem_ren) begin
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (dmem_wen) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if ((dmem_ren && !raddr_ok) || (dmem_wen && !waddr_ok)) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Write-first: a same-cycle store to the load address is forwarded.
  always_comb begin
    ld_data = '0;
    if (raddr_ok) begin
      if (dmem_wen && (dmem_waddr == dmem_raddr)) begin
        ld_data = dmem_wdata;
      end else begin
        ld_data = mem[dmem_raddr[IDX_W-1:0]];
      end
    end
  end

  always_comb begin
    pv_d[0] = ld_acc;
    pd_d[0] = ld_data;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StReset;
      ptr_q    <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Stage data only moves with a valid token, so the output holds its last delivered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q <= pv_d;
      for (int i = 0; i < RD_LAT; i++) begin
        if (pv_d[i]) begin
          pd_q[i] <= pd_d[i];
        end
      end
    end
  end

  // Storage is never written while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign dmem_rvalid = pv_q[RD_LAT-1];
  assign dmem_rdata  = pd_q[RD_LAT-1];
  assign busy        = (state_q == StInit);
  assign err_oob     = err_q;
  assign rd_cnt      = rd_cnt_q;
  assign wr_cnt      = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance a (DEPTH=16, RD_LAT=2) and instance b
// (DEPTH=4000, RD_LAT=4), both zero-filling after reset.
module tb_dmem_responder;

  logic        clk;
  logic        a_rst, a_ren, a_wen, a_rvalid, a_busy, a_err;
  logic [11:0] a_raddr, a_waddr;
  logic [31:0] a_wdata, a_rdata;
  logic [15:0] a_rd_cnt, a_wr_cnt;
  logic        b_rst, b_ren, b_wen, b_rvalid, b_busy, b_err;
  logic [11:0] b_raddr, b_waddr;
  logic [31:0] b_wdata, b_rdata;
  logic [15:0] b_rd_cnt, b_wr_cnt;

  int total = 0;
  int bad   = 0;

  dmem_responder #(
    .ADDR_W(12), .DATA_W(32), .DEPTH(16), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)
  ) u_a (
    .clk(clk), .rst(a_rst), .dmem_ren(a_ren), .dmem_raddr(a_raddr), .dmem_wen(a_wen),
    .dmem_waddr(a_waddr), .dmem_wdata(a_wdata), .dmem_rdata(a_rdata), .dmem_rvalid(a_rvalid),
    .busy(a_busy), .err_oob(a_err), .rd_cnt(a_rd_cnt), .wr_cnt(a_wr_cnt)
  );

  dmem_responder #(
    .ADDR_W(12), .DATA_W(32), .DEPTH(4000), .RD_LAT(4), .CLEAR_ON_RESET(1'b1)
  ) u_b (
    .clk(clk), .rst(b_rst), .dmem_ren(b_ren), .dmem_raddr(b_raddr), .dmem_wen(b_wen),
    .dmem_waddr(b_waddr), .dmem_wdata(b_wdata), .dmem_rdata(b_rdata), .dmem_rvalid(b_rvalid),
    .busy(b_busy), .err_oob(b_err), .rd_cnt(b_rd_cnt), .wr_cnt(b_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic [11:0] raddr;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic vec_t v(logic ren, logic [11:0] ra, logic wen, logic [11:0] wa,
                             logic [31:0] wd, logic rv, logic [31:0] rd, logic er);
    vec_t r;
    r.ren = ren; r.raddr = ra; r.wen = wen; r.waddr = wa; r.wdata = wd;
    r.exp_rv = rv; r.exp_rd = rd; r.exp_err = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic ren, input logic [11:0] ra, input logic wen,
                         input logic [11:0] wa, input logic [31:0] wd);
    a_ren = ren; a_raddr = ra; a_wen = wen; a_waddr = wa; a_wdata = wd;
  endtask

  task automatic drive_b(input logic ren, input logic [11:0] ra, input logic wen,
                         input logic [11:0] wa, input logic [31:0] wd);
    b_ren = ren; b_raddr = ra; b_wen = wen; b_waddr = wa; b_wdata = wd;
  endtask

  // Counts edges until busy drops (bounded), and how many of them showed rvalid.
  task automatic wait_fill(input bit sel, input int lim, output int n, output int rv_seen);
    n = 0;
    rv_seen = 0;
    while ((sel ? b_busy : a_busy) && n < lim) begin
      step();
      n++;
      if (sel ? b_rvalid : a_rvalid) rv_seen++;
    end
  endtask

  task automatic chk_reset_state(input bit sel, input string nm);
    chk({nm, " busy"},   sel ? b_busy   : a_busy,   1);
    chk({nm, " rvalid"}, sel ? b_rvalid : a_rvalid, 0);
    chk({nm, " rdata"},  sel ? b_rdata  : a_rdata,  0);
    chk({nm, " err"},    sel ? b_err    : a_err,    0);
    chk({nm, " rd_cnt"}, sel ? b_rd_cnt : a_rd_cnt, 0);
    chk({nm, " wr_cnt"}, sel ? b_wr_cnt : a_wr_cnt, 0);
  endtask

  // Single load on b: invisible for 3 cycles, delivered in the 4th, then strobe ends.
  task automatic b_load(input logic [11:0] addr, input logic [31:0] exp, input string nm);
    drive_b(1'b1, addr, 1'b0, 12'd0, 32'd0);
    step();
    drive_b(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    repeat (2) begin
      step();
      chk({nm, " early rvalid"}, b_rvalid, 0);
    end
    step();
    chk({nm, " rvalid"}, b_rvalid, 1);
    chk({nm, " rdata"}, b_rdata, exp);
    step();
    chk({nm, " strobe end"}, b_rvalid, 0);
  endtask

  vec_t vecs [19];

  initial begin
    int n, rv;

    vecs[0]  = v(0, 0,  1, 5,  32'hDEADBEEF, 0, 32'h0,        0);
    vecs[1]  = v(1, 5,  0, 0,  32'h0,        0, 32'h0,        0);
    vecs[2]  = v(0, 0,  0, 0,  32'h0,        1, 32'hDEADBEEF, 0);
    vecs[3]  = v(0, 0,  0, 0,  32'h0,        0, 32'hDEADBEEF, 0);
    vecs[4]  = v(0, 0,  1, 1,  32'h11,       0, 32'hDEADBEEF, 0);
    vecs[5]  = v(0, 0,  1, 2,  32'h22,       0, 32'hDEADBEEF, 0);
    vecs[6]  = v(1, 1,  1, 3,  32'h33,       0, 32'hDEADBEEF, 0);
    vecs[7]  = v(1, 2,  0, 0,  32'h0,        1, 32'h11,       0);
    vecs[8]  = v(1, 3,  0, 0,  32'h0,        1, 32'h22,       0);
    vecs[9]  = v(0, 0,  0, 0,  32'h0,        1, 32'h33,       0);
    vecs[10] = v(0, 0,  0, 0,  32'h0,        0, 32'h33,       0);
    vecs[11] = v(1, 7,  1, 7,  32'h12345678, 0, 32'h33,       0);
    vecs[12] = v(0, 0,  1, 7,  32'hAAAA5555, 1, 32'h12345678, 0);
    vecs[13] = v(1, 7,  0, 0,  32'h0,        0, 32'h12345678, 0);
    vecs[14] = v(0, 0,  0, 0,  32'h0,        1, 32'hAAAA5555, 0);
    vecs[15] = v(1, 20, 0, 0,  32'h0,        0, 32'hAAAA5555, 1);
    vecs[16] = v(0, 0,  1, 16, 32'hFFFF,     1, 32'h0,        1);
    vecs[17] = v(1, 0,  0, 0,  32'h0,        0, 32'h0,        1);
    vecs[18] = v(0, 0,  0, 0,  32'h0,        1, 32'h0,        1);

    a_rst = 1'b0;
    b_rst = 1'b0;
    drive_a(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    drive_b(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    #12;
    chk_reset_state(0, "a reset");
    chk_reset_state(1, "b reset");

    // Requests held high during the fill must be ignored.
    @(negedge clk);
    a_rst = 1'b1;
    b_rst = 1'b1;
    drive_a(1'b1, 12'd0, 1'b1, 12'd0, 32'hFFFFFFFF);
    wait_fill(0, 100, n, rv);
    chk("a fill cycles", n, 16);
    chk("a rvalid during fill", rv, 0);
    drive_a(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    chk("a rd_cnt after fill", a_rd_cnt, 0);
    chk("a wr_cnt after fill", a_wr_cnt, 0);
    chk("a err after fill", a_err, 0);

    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 12'(i), 1'b0, 12'd0, 32'd0);
      step();
      chk($sformatf("a sweep%0d rvalid", i), a_rvalid, (i >= 1));
      chk($sformatf("a sweep%0d rdata", i), a_rdata, 0);
    end
    drive_a(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    step();
    chk("a sweep last rvalid", a_rvalid, 1);
    chk("a sweep last rdata", a_rdata, 0);
    chk("a sweep rd_cnt", a_rd_cnt, 16);

    for (int i = 0; i < 19; i++) begin
      drive_a(vecs[i].ren, vecs[i].raddr, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
      step();
      chk($sformatf("vec%0d rvalid", i), a_rvalid, vecs[i].exp_rv);
      chk($sformatf("vec%0d rdata", i), a_rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d err", i), a_err, vecs[i].exp_err);
    end
    drive_a(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    chk("a rd_cnt total", a_rd_cnt, 24);
    chk("a wr_cnt total", a_wr_cnt, 7);

    // Dirty word 15, then reset mid-fill: the restarted fill must clear it again.
    drive_a(1'b0, 12'd0, 1'b1, 12'd15, 32'h5A5A);
    step();
    drive_a(1'b1, 12'd15, 1'b0, 12'd0, 32'd0);
    step();
    drive_a(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    step();
    chk("a word15 dirty", a_rdata, 32'h5A5A);
    a_rst = 1'b0;
    #1;
    chk_reset_state(0, "a rst1");
    @(negedge clk);
    a_rst = 1'b1;
    repeat (5) step();
    chk("a midfill busy", a_busy, 1);
    a_rst = 1'b0;
    #1;
    chk_reset_state(0, "a midfill rst");
    @(negedge clk);
    a_rst = 1'b1;
    wait_fill(0, 100, n, rv);
    chk("a refill cycles", n, 16);
    drive_a(1'b1, 12'd15, 1'b0, 12'd0, 32'd0);
    step();
    drive_a(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    step();
    chk("a word15 cleared rvalid", a_rvalid, 1);
    chk("a word15 cleared rdata", a_rdata, 0);

    wait_fill(1, 5000, n, rv);
    chk("b fill done", b_busy, 0);

    drive_b(1'b0, 12'd0, 1'b1, 12'd3999, 32'h1234);
    step();
    chk("b err after in-range store", b_err, 0);
    drive_b(1'b0, 12'd0, 1'b1, 12'd4000, 32'hFFFF);
    step();
    chk("b err after oob store", b_err, 1);
    b_load(12'd4000, 32'h0, "b load 4000");
    b_load(12'd3999, 32'h1234, "b load 3999");

    drive_b(1'b1, 12'd7, 1'b1, 12'd7, 32'h12345678);
    step();
    drive_b(1'b0, 12'd0, 1'b1, 12'd7, 32'hAAAA5555);
    step();
    drive_b(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    step();
    chk("b wf early rvalid", b_rvalid, 0);
    step();
    chk("b wf rvalid", b_rvalid, 1);
    chk("b wf rdata", b_rdata, 32'h12345678);
    b_load(12'd7, 32'hAAAA5555, "b load 7");
    chk("b rd_cnt", b_rd_cnt, 4);
    chk("b wr_cnt", b_wr_cnt, 4);

    // Two loads in flight, then reset: neither may ever be delivered.
    drive_b(1'b1, 12'd7, 1'b0, 12'd0, 32'd0);
    step();
    step();
    drive_b(1'b0, 12'd0, 1'b0, 12'd0, 32'd0);
    b_rst = 1'b0;
    #1;
    chk_reset_state(1, "b midload rst");
    step();
    step();
    chk("b rvalid in reset", b_rvalid, 0);
    @(negedge clk);
    b_rst = 1'b1;
    wait_fill(1, 5000, n, rv);
    chk("b refill cycles", n, 4000);
    chk("b rvalid during refill", rv, 0);
    b_load(12'd3999, 32'h0, "b refilled 3999");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
